// File: rtl/timer_apb_pkg.sv
// Shared types and constants for the timer APB arbiter.
package timer_apb_pkg;

  localparam int unsigned ApbAddrW          = 8;
  localparam int unsigned ApbDataW          = 8;
  localparam int unsigned TimeoutCycDefault = 16;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess
  } apb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: combinational one-hot grant, pointer advances past the winner on upd_i.
module rr_arbiter #(
  parameter int unsigned N    = 2,
  parameter int unsigned IdxW = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            upd_i,
  input  logic [N-1:0]    req_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] gnt_idx_o
);

  logic [IdxW-1:0] ptr_q;
  logic [IdxW-1:0] idx;
  logic            found;

  // Scan from the pointer upward, wrapping; first requester found wins.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = IdxW'((32'(ptr_q) + k) % N);
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = idx;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else if (upd_i) begin
      ptr_q <= IdxW'((32'(gnt_idx_o) + 32'd1) % N);
    end
  end

endmodule

// File: rtl/timer_apb_arbiter.sv
// APB master sharing the timer's slave port among N_REQ requesters, one transfer at a time.
// Define TIMER_APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYC wait cycles with rsp_err set.
module timer_apb_arbiter
  import timer_apb_pkg::*;
#(
  parameter int unsigned N_REQ       = 2,
  parameter int unsigned TIMEOUT_CYC = TimeoutCycDefault
) (
  input  logic                      pclk,
  input  logic                      preset,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ-1:0]          req_write,
  input  logic [N_REQ*ApbAddrW-1:0] req_addr,
  input  logic [N_REQ*ApbDataW-1:0] req_wdata,
  output logic [N_REQ-1:0]          req_ready,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [ApbDataW-1:0]       rsp_rdata,
  output logic                      rsp_err,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [ApbAddrW-1:0]       paddr,
  output logic [ApbDataW-1:0]       pwdata,
  input  logic [ApbDataW-1:0]       prdata,
  input  logic                      pready
);

  localparam int unsigned IdxW = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC == 0) begin : g_param_err
    $error("timer_apb_arbiter: N_REQ must be 2..8 and TIMEOUT_CYC nonzero");
  end

  apb_state_e      state_q, state_d;
  logic [N_REQ-1:0] gnt;
  logic [IdxW-1:0] gnt_idx, idx_q;
  logic            accept, done, timeout;

  rr_arbiter #(
    .N    (N_REQ),
    .IdxW (IdxW)
  ) u_rr_arbiter (
    .clk_i     (pclk),
    .rst_i     (preset),
    .upd_i     (accept),
    .req_i     (req_valid),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

`ifdef TIMER_APB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
  logic [CntW-1:0] wait_q;
  logic            err_q;

  // Fires on the wait cycle that would bring the counter to TIMEOUT_CYC.
  assign timeout = !pready && (wait_q == CntW'(TIMEOUT_CYC - 1));
  assign rsp_err = err_q;

  always_ff @(posedge pclk) begin
    if (preset) begin
      wait_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state_q == StSetup) begin
        wait_q <= '0;
      end else if (state_q == StAccess && !pready) begin
        wait_q <= wait_q + 1'b1;
      end
      if (done) begin
        err_q <= timeout;
      end
    end
  end
`else
  assign timeout = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|req_valid) begin
          accept  = 1'b1;
          state_d = StSetup;
        end
      end
      StSetup:  state_d = StAccess;
      StAccess: begin
        if (pready || timeout) begin
          done    = 1'b1;
          state_d = StIdle;
        end
      end
      default:  state_d = StIdle;
    endcase
  end

  assign psel      = (state_q != StIdle);
  assign penable   = (state_q == StAccess);
  assign req_ready = (state_q == StIdle && !preset) ? gnt : '0;

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
    end else begin
      state_q   <= state_d;
      rsp_valid <= '0;
      if (accept) begin
        idx_q  <= gnt_idx;
        pwrite <= req_write[gnt_idx];
        paddr  <= req_addr[gnt_idx*ApbAddrW +: ApbAddrW];
        pwdata <= req_wdata[gnt_idx*ApbDataW +: ApbDataW];
      end
      if (done) begin
        rsp_valid <= N_REQ'(1) << idx_q;
        rsp_rdata <= (pwrite || timeout) ? '0 : prdata;
      end
    end
  end

endmodule

// File: doc/timer_apb_arbiter.md
# timer_apb_arbiter

APB master that shares the 8-bit timer's single APB slave port between N_REQ on-chip requesters. Round-robin arbitration with one outstanding transfer at a time. Drives the standard two-phase APB SETUP/ACCESS sequence, waits on pready, and routes prdata back to the granted requester. Sits between the requester fabric and the timer's psel/penable/pwrite/paddr/pwdata/prdata/pready pins.

## Interface
Parameters:
- N_REQ, 2: number of requesters (2..8).
- TIMEOUT_CYC, 16: ACCESS-phase wait limit in cycles (used only with TIMER_APB_TIMEOUT_EN).

Ports:
- pclk  in  1  single clock, all logic rising-edge.
- preset  in  1  reset, synchronous, active-high.
- req_valid  in  N_REQ  per-requester transfer request; held until accepted.
- req_write  in  N_REQ  1 = write, 0 = read.
- req_addr  in  N_REQ*8  per-requester address, requester i at [8i+7:8i].
- req_wdata  in  N_REQ*8  per-requester write data, same packing.
- req_ready  out  N_REQ  one-hot, one-cycle acceptance pulse.
- rsp_valid  out  N_REQ  one-hot, one-cycle completion pulse.
- rsp_rdata  out  8  read data, valid with rsp_valid (0x00 for writes).
- rsp_err  out  1  timeout flag, valid with rsp_valid.
- psel, penable, pwrite  out  1 each  APB control.
- paddr, pwdata  out  8 each  APB address/write data.
- prdata  in  8  APB read data.
- pready  in  1  APB ready.

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: if any req_valid, grant highest-priority requester. Pulse its req_ready, capture write/addr/wdata into internal registers, go SETUP. Else stay.
- SETUP: psel=1, penable=0, paddr/pwdata/pwrite from captured registers. Always exactly one cycle, then ACCESS.
- ACCESS: psel=1, penable=1, same address/data. On pready=1: capture prdata (reads only), go IDLE, and set rsp_valid for the granted index next cycle. On pready=0: stay.
- Round-robin: priority pointer starts at requester 0. After granting i, requester (i+1) mod N_REQ becomes highest priority. The pointer advances only on grant.
- In IDLE, psel=penable=0 and paddr/pwdata/pwrite hold their last values.
- Requesters hold req_valid and their fields stable until req_ready. req_valid dropped before acceptance is legal; the request is simply not granted.
- rsp_valid for transfer k and req_ready for transfer k+1 may pulse in the same cycle.
- Reset values: state IDLE, pointer 0, all outputs 0 (psel, penable, pwrite, paddr, pwdata, req_ready, rsp_valid, rsp_rdata, rsp_err).
- Reset mid-transfer: psel/penable are 0 after the reset edge. No rsp_valid is issued for the aborted transfer, and it is not retried.

## Timing
- Accept at edge 0 (IDLE, req_ready high in cycle 0) -> SETUP cycle 1 -> ACCESS cycle 2. With pready=1 in cycle 2, rsp_valid is high in cycle 3 (IDLE).
- Minimum transfer: 3 cycles accept-to-response. Each wait-state adds 1 cycle.
- Back-to-back throughput: one transfer per 3 cycles, because the next accept happens in the IDLE cycle carrying rsp_valid.
- prdata is sampled only on the cycle where ACCESS && pready.

## Configuration
- TIMER_APB_TIMEOUT_EN defined:
  - A wait counter clears on entering ACCESS and increments each ACCESS cycle with pready=0.
  - When the counter reaches TIMEOUT_CYC, the FSM goes to IDLE and rsp_valid pulses next cycle with rsp_err=1 and rsp_rdata=0x00.
  - psel/penable drop with the IDLE transition.
- TIMER_APB_TIMEOUT_EN undefined: no counter, rsp_err tied to 0, and ACCESS waits on pready indefinitely.

## Structure
- Shared package timer_apb_pkg:
  - state enum (IDLE/SETUP/ACCESS)
  - APB address/data width constants (8)
  - default TIMEOUT_CYC
- Sub-module rr_arbiter: N_REQ-wide round-robin grant with pointer update. Combinational grant plus a registered pointer, with an update strobe from the FSM.

## Test plan
- Single read: req 0 reads 0x04 while the slave returns 0xA5 with no wait -> req_ready[0] at cycle 0, psel at cycle 1, penable at cycle 2, rsp_valid[0] with rsp_rdata=0xA5 at cycle 3.
- Write with 2 wait-states: req 1 writes 0x3C to 0x02 -> ACCESS held 3 cycles, pwdata=0x3C stable throughout, rsp_valid[1] at cycle 5, rsp_rdata=0x00.
- Contention: req 0 and req 1 both held valid for 4 transfers -> grants alternate 0,1,0,1, and neither requester is starved.
- Back-to-back: req 0 valid continuously for 3 writes -> req_ready pulses in the same cycle as the previous rsp_valid, at a 3-cycle period.
- Reset mid-ACCESS: assert preset while pready=0 -> psel=penable=0 and all outputs 0 after the edge, no rsp_valid, and the next grant goes to req 0.
- Timeout (TIMER_APB_TIMEOUT_EN, TIMEOUT_CYC=16): pready held 0 -> rsp_valid with rsp_err=1 and rsp_rdata=0x00 exactly 16 ACCESS cycles after ACCESS entry +1.
